// File: rtl/fix14_dot_product_seq_if.sv
// ============================================================================
// fix14_dot_product_seq_if : request, operand-memory, multiplier and result bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface fix14_dot_product_seq_if #(
    parameter int D_W    = 16,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [D_W-1:0]    x_data;
    logic [D_W-1:0]    h_data;
    logic              mul_CE;
    logic [D_W-1:0]    mul_A;
    logic [D_W-1:0]    mul_B;
    logic [D_W-1:0]    mul_P;
    logic              busy;
    logic              done;
    logic [D_W-1:0]    result;
    logic              sat;

    // Control logic, operand memories and the multiplier sit on the master side
    modport master (
        output start, len, x_data, h_data, mul_P,
        input  rd_en, rd_addr, mul_CE, mul_A, mul_B, busy, done, result, sat
    );

    modport slave (
        input  start, len, x_data, h_data, mul_P,
        output rd_en, rd_addr, mul_CE, mul_A, mul_B, busy, done, result, sat
    );
endinterface

`default_nettype wire

// File: rtl/fix14_dot_product_seq.sv
// ============================================================================
// fix14_dot_product_seq : saturated Q2.14 dot product over a shared multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module fix14_dot_product_seq #(
    parameter int D_W    = 16,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 24
) (
    input  wire logic               sys_clk,
    input  wire logic               sys_rst,
    fix14_dot_product_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] c_sat_hi = ACC_W'((1 << (D_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] c_sat_lo = ~c_sat_hi;
    localparam logic [D_W-1:0]          c_res_hi = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0]          c_res_lo = {1'b1, {(D_W-1){1'b0}}};

    state_t                   r_state;
    logic [ADDR_W-1:0]        r_addr;
    logic [ADDR_W-1:0]        r_len;
    logic                     r_rd_en;
    logic                     r_v0;
    logic                     r_v1;
    logic [D_W-1:0]           r_mul_a;
    logic [D_W-1:0]           r_mul_b;
    logic signed [ACC_W-1:0]  r_acc;
    logic [D_W-1:0]           r_result;
    logic                     r_sat;
    logic                     r_done;
    logic                     r_busy;

    logic signed [ACC_W-1:0]  w_prod_ext;
    logic [D_W-1:0]           w_clamp;
    logic                     w_clamped;

    assign w_prod_ext = {{(ACC_W-D_W){bus.mul_P[D_W-1]}}, bus.mul_P};

    always_comb begin
        w_clamp   = r_acc[D_W-1:0];
        w_clamped = 1'b0;
        if (r_acc > c_sat_hi) begin
            w_clamp   = c_res_hi;
            w_clamped = 1'b1;
        end else if (r_acc < c_sat_lo) begin
            w_clamp   = c_res_lo;
            w_clamped = 1'b1;
        end
    end

    // r_v0 marks the cycle memory data is valid; r_v1 marks a valid product on mul_P
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_len    <= '0;
            r_rd_en  <= 1'b0;
            r_v0     <= 1'b0;
            r_v1     <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_sat    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_v0   <= r_rd_en;
            r_v1   <= r_v0;
            if (r_v0) begin
                r_mul_a <= bus.x_data;
                r_mul_b <= bus.h_data;
            end
            if (r_v1) begin
                r_acc <= r_acc + w_prod_ext;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc  <= '0;
                        r_addr <= '0;
                        r_v0   <= 1'b0;
                        r_v1   <= 1'b0;
                        r_len  <= bus.len;
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_state <= ST_RUN;
                            r_rd_en <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_addr == r_len - ADDR_W'(1)) begin
                        r_state <= ST_DRAIN;
                        r_rd_en <= 1'b0;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Last product is being accumulated at this edge
                    if (r_v1 && !r_v0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_result <= w_clamp;
                    r_sat    <= w_clamped;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rd_en   = r_rd_en;
    assign bus.rd_addr = r_addr;
    assign bus.mul_CE  = r_busy;
    assign bus.mul_A   = r_mul_a;
    assign bus.mul_B   = r_mul_b;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.sat     = r_sat;

endmodule

`default_nettype wire

// File: doc/fix14_dot_product_seq.md
# fix14_dot_product_seq

Sequencer that computes a saturated Q2.14 dot product of two operand vectors on the shared signed fix14.16 multiplier. It streams `len` operand pairs from two single-port operand memories (shared address, 1-cycle read latency), drives the multiplier, accumulates products in a wide fabric accumulator and returns one clamped 16-bit result with a done pulse. It sits between the filter/state-machine control logic and one `SB_MAC16`-based 16x16 fix14 multiplier instance.

## Interface
- `D_W`, 16: operand, product and result width (Q2.14).
- `ADDR_W`, 5: operand memory address width; maximum `len` is 2^ADDR_W − 1.
- `ACC_W`, 24: signed accumulator width; must be ≥ D_W + ADDR_W.

- `sys_clk`  in  1  sole clock; everything is rising-edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a dot product; sampled only in IDLE.
- `len`  in  ADDR_W  number of pairs; sampled with `start`.
- `rd_en`  out  1  operand memory read enable.
- `rd_addr`  out  ADDR_W  operand address, shared by both memories.
- `x_data`  in  D_W  sample operand, valid the cycle after `rd_en`.
- `h_data`  in  D_W  coefficient operand, valid the cycle after `rd_en`.
- `mul_CE`  out  1  multiplier clock enable.
- `mul_A`  out  D_W  multiplier operand A (registered x).
- `mul_B`  out  D_W  multiplier operand B (registered h).
- `mul_P`  in  D_W  multiplier fix14 product (`O[29:14]`), combinational from `mul_A`/`mul_B`.
- `busy`  out  1  high from the start-accept edge until done.
- `done`  out  1  one-cycle pulse; `result`/`sat` are valid from this cycle.
- `result`  out  D_W  saturated signed dot product; held until the next `done`.
- `sat`  out  1  result was clamped; held with `result`.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: issues addresses 0..len−1, one per cycle, with `rd_en`=1.
  - DRAIN: flushes the 2-stage pipeline with `rd_en`=0.
  - DONE: registers the result.
- Transitions:
  - IDLE→RUN on `start` when `len`≠0.
  - IDLE→DONE on `start` when `len`=0.
  - RUN→DRAIN after address len−1 is issued.
  - DRAIN→DONE after the last product is accumulated.
  - DONE→IDLE after one cycle.
- On start accept: accumulator ← 0, address counter ← 0, pipeline valid bits ← 0.
- Pipeline stages:
  - S0: address issue.
  - S1: capture `x_data`/`h_data` into the `mul_A`/`mul_B` registers, tagged valid.
  - S2: acc ← acc + sign-extend(`mul_P`), only when the S1 tag is valid.
- No stale or idle product is ever accumulated.
- Result rule:
  - acc > 32767 → `result`=0x7FFF, `sat`=1.
  - acc < −32768 → `result`=0x8000, `sat`=1.
  - Otherwise `result`=acc[D_W−1:0], `sat`=0.
- With the ACC_W rule, the accumulator never wraps.
- `mul_CE`=`busy`. `mul_A`/`mul_B` hold their last value when not loading.
- `start` while `busy`=1 is ignored (not queued).

## Timing
- Let E0 be the edge that accepts `start`.
  - Address k is driven in the cycle after E_k.
  - It is captured into operand registers at E_{k+2}.
  - It is accumulated at E_{k+3}.
  - `done` is high in the cycle after E_{len+3}, i.e. latency len+3 cycles.
- `len`=0: `done` is high in the cycle after E1, `result`=0, `sat`=0.
- `start` may be reasserted in the cycle `done` is high; it is accepted one cycle later, from IDLE.
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `mul_CE`=0, `mul_A`=0, `mul_B`=0, `result`=0, `sat`=0, accumulator=0, state=IDLE.
- `sys_rst` mid-operation: all of the above apply at the next edge and the run is abandoned with no `done`. `sys_rst` takes priority over `start` in the same cycle.

## Test plan
- len=3, x={0x4000,0xC000,0x2000}, h={0x2000,0x2000,0x4000} → products 0x2000, 0xE000, 0x2000; `result`=0x2000, `sat`=0; `done` exactly 6 cycles after the accept edge; `rd_addr` sequence 0,1,2.
- len=4, all x=0x4000, all h=0x2000 → sum 0x8000 overflows positive; `result`=0x7FFF, `sat`=1, `done` after 7 cycles.
- len=2, x=0x8000, h=0x4000 → sum −65536; `result`=0x8000, `sat`=1.
- len=0 → `done` the cycle after accept, `result`=0, `sat`=0, `rd_en` never asserted.
- Pulse `start` with len=5 during a len=3 run → ignored; single `done` at 6 cycles with the len=3 result; the next `start` after `done` is accepted.
- Assert `sys_rst` mid-run during RUN at address 2 → next cycle `busy`/`rd_en`/`mul_CE`=0 and `result`/`sat`=0; no `done`; a fresh len=3 run then yields 0x2000 with no residue from the aborted accumulation.
